fir_ntap: RTL

FIR_NTAP -- requirements
Module: fir_ntap

---
 rtl/fir_ntap.sv | 113 +++++++++++
 1 files changed

// File: rtl/fir_ntap.sv
// Time-multiplexed N-tap FIR: one shared multiplier, one product per cycle.
// Define FIR_NTAP_SAT_EN to saturate y on overflow; otherwise y wraps.
module fir_ntap #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned NTAPS = 8,
  parameter int unsigned FRAC  = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic signed [DW-1:0]         x,
  output logic                         in_ready,
  input  logic                         coef_we,
  input  logic [$clog2(NTAPS)-1:0]     coef_addr,
  input  logic signed [CW-1:0]         coef_data,
  output logic signed [DW-1:0]         y,
  output logic                         out_valid,
  output logic                         ovf
);

  localparam int unsigned AW   = $clog2(NTAPS);
  localparam int unsigned PW   = DW + CW;
  localparam int unsigned ACCW = DW + CW + AW;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                 state_q;
  logic [AW-1:0]          cnt_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [DW-1:0]   dly_q  [NTAPS];
  logic signed [CW-1:0]   coef_q [NTAPS];
  logic signed [DW-1:0]   y_q;
  logic                   out_valid_q;
  logic                   ovf_q;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] sum_sh;
  logic                   ovf_c;
  logic signed [DW-1:0]   y_c;

  always_comb begin
    prod     = coef_q[cnt_q] * dly_q[cnt_q];
    prod_ext = {{AW{prod[PW-1]}}, prod};
    sum_sh   = acc_q >>> FRAC;
    // Fits in DW signed iff every bit from DW-1 upward equals the sign bit.
    ovf_c    = !((&sum_sh[ACCW-1:DW-1]) || !(|sum_sh[ACCW-1:DW-1]));
`ifdef FIR_NTAP_SAT_EN
    if (ovf_c) begin
      y_c = sum_sh[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      y_c = sum_sh[DW-1:0];
    end
`else
    y_c = sum_sh[DW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        dly_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else if (en) begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Coefficient written on the accept edge is seen by the MAC that follows.
          if (coef_we) coef_q[coef_addr] <= coef_data;
          if (in_valid) begin
            dly_q[0] <= x;
            for (int k = 1; k < NTAPS; k++) dly_q[k] <= dly_q[k-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + prod_ext;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(NTAPS - 1)) state_q <= DONE;
        end
        DONE: begin
          y_q         <= y_c;
          ovf_q       <= ovf_c;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end else begin
      // Frozen: everything holds except the result strobes, which drop.
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule
